// File: rtl/demux_pkg.sv
// ----------------------------------------------------------------------------
// demux_pkg : shared constants and helpers for the demux2_stream block.
// Revision  : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package demux_pkg;

  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 2;
  localparam int DEF_CNT_W = 16;

  // Pointer width for a power-of-two FIFO; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage : demux_pkg

`default_nettype wire

// File: rtl/demux2_fifo.sv
// ----------------------------------------------------------------------------
// demux2_fifo : small per-output FIFO with separate occupancy counter.
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module demux2_fifo
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);

  localparam int PW = ptr_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW:0]      occ;
  logic             do_push;
  logic             do_pop;

  assign full       = (occ == (PW+1)'(DEPTH));
  assign head_valid = (occ != '0);
  assign head_data  = mem[rd_ptr];

  // A push into a full FIFO is refused even when a pop happens the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && head_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + (PW+1)'(1);
        2'b01:   occ <= occ - (PW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule : demux2_fifo

`default_nettype wire

// File: rtl/demux2_stream.sv
// ----------------------------------------------------------------------------
// demux2_stream : 1-to-2 streaming demux with per-output FIFOs and counters.
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module demux2_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic             full0;
  logic             full1;
  logic             head_valid0;
  logic             head_valid1;
  logic [WIDTH-1:0] head_data0;
  logic [WIDTH-1:0] head_data1;
  logic             accept;
  logic             push0;
  logic             push1;

  // Ready depends only on the selected FIFO's fullness, never on the consumers.
  assign in_ready = rst_n && ((in_sel == SEL_OUT1) ? !full1 : !full0);
  assign accept   = in_valid && in_ready;
  assign push0    = accept && (in_sel == SEL_OUT0);
  assign push1    = accept && (in_sel == SEL_OUT1);

  demux2_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push0),
    .push_data  (in_data),
    .full       (full0),
    .pop        (out0_ready),
    .head_valid (head_valid0),
    .head_data  (head_data0)
  );

  demux2_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push1),
    .push_data  (in_data),
    .full       (full1),
    .pop        (out1_ready),
    .head_valid (head_valid1),
    .head_data  (head_data1)
  );

  assign out0_valid = head_valid0;
  assign out1_valid = head_valid1;
  assign out0_data  = head_valid0 ? head_data0 : '0;
  assign out1_data  = head_valid1 ? head_data1 : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (push0 && (cnt0 != '1)) cnt0 <= cnt0 + CNT_W'(1);
      if (push1 && (cnt1 != '1)) cnt1 <= cnt1 + CNT_W'(1);
    end
  end

  // Producer must hold a stalled word unchanged until it is taken.
  a_producer_hold : assert property (@(posedge clk)
    (rst_n && in_valid && !in_ready) |=>
      (!rst_n || !in_valid || ((in_sel == $past(in_sel)) && (in_data == $past(in_data)))));

endmodule : demux2_stream

`default_nettype wire
